// File: rtl/gearbox_rx.sv
// Receive gearbox for 64b/66b: packs PMA words into 66-bit blocks (2-bit header + 64-bit payload)
// with a bit-granular slip so block lock can walk the boundary onto the sync headers.
module gearbox_rx #(
  parameter int DATA_W       = 64,
  parameter int BLOCK_DATA_W = 64,
  parameter int HEAD_W       = 2,
  parameter int OFF_W        = $clog2(DATA_W)
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic [DATA_W-1:0]       data_i,
  input  logic                    slip_v_i,
  output logic                    valid_o,
  output logic [HEAD_W-1:0]       head_o,
  output logic [BLOCK_DATA_W-1:0] data_o
);

  localparam int BLK_W  = BLOCK_DATA_W + HEAD_W;
  localparam int BUF_W  = BLK_W + DATA_W;
  localparam int FILL_W = $clog2(BUF_W + 1);

  logic [DATA_W-1:0]       word_q;
  logic [OFF_W-1:0]        off_q, off_d;
  logic                    first_q;
  logic                    skip_q, skip_d;
  logic [BUF_W-1:0]        buf_q, buf_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic                    valid_q, valid_d;
  logic [HEAD_W-1:0]       head_q, head_d;
  logic [BLOCK_DATA_W-1:0] data_q, data_d;

  logic [DATA_W-1:0]       aligned;
  logic                    push;
  logic [BUF_W-1:0]        merged;
  logic [FILL_W-1:0]       next_fill;

  always_comb begin
    aligned = DATA_W'({data_i, word_q} >> off_q);
    // When off wraps to 0, word_q holds bits already consumed at off=DATA_W-1; drop that push.
    push    = first_q && !skip_q;
    off_d   = slip_v_i ? off_q + OFF_W'(1) : off_q;
    skip_d  = slip_v_i && (off_q == OFF_W'(DATA_W - 1));

    merged    = buf_q | ({{BLK_W{1'b0}}, aligned} << fill_q);
    next_fill = fill_q + FILL_W'(DATA_W);

    buf_d   = buf_q;
    fill_d  = fill_q;
    valid_d = 1'b0;
    head_d  = head_q;
    data_d  = data_q;
    if (push) begin
      if (next_fill >= FILL_W'(BLK_W)) begin
        valid_d = 1'b1;
        head_d  = merged[HEAD_W-1:0];
        data_d  = merged[BLK_W-1:HEAD_W];
        buf_d   = merged >> BLK_W;
        fill_d  = next_fill - FILL_W'(BLK_W);
      end else begin
        buf_d  = merged;
        fill_d = next_fill;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      word_q  <= '0;
      off_q   <= '0;
      first_q <= 1'b0;
      skip_q  <= 1'b0;
      buf_q   <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
      data_q  <= '0;
    end else begin
      word_q  <= data_i;
      off_q   <= off_d;
      first_q <= 1'b1;
      skip_q  <= skip_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign head_o  = head_q;
  assign data_o  = data_q;

endmodule
